// File: rtl/mesh_sort_sched.sv
// Shearsort phase scheduler: streams N*(2*LOG_N+1) compare-exchange step commands
// (alternating row/column phases of N odd-even steps) to the mesh over valid/ready.
module mesh_sort_sched #(
  parameter int LOG_N = 2,
  parameter int N     = 4,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_row,
  output logic             cmd_odd,
  output logic [PH_W-1:0]  cmd_phase,
  output logic [LOG_N-1:0] cmd_step,
  output logic             cmd_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(2 * LOG_N);
  localparam logic [LOG_N-1:0] LAST_STEP  = LOG_N'(N - 1);

  state_t state_q, state_d;

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [LOG_N-1:0] step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_row_q, cmd_row_d;
  logic             cmd_odd_q, cmd_odd_d;
  logic             cmd_last_q, cmd_last_d;
  logic             xfer;
  logic             issue_d;

  assign xfer = cmd_valid_q & cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_row_q   <= 1'b0;
      cmd_odd_q   <= 1'b0;
      cmd_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_row_q   <= cmd_row_d;
      cmd_odd_q   <= cmd_odd_d;
      cmd_last_q  <= cmd_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (xfer && cmd_last_q) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state and next counters, so the
  // command after a transfer appears on the very next cycle with no bubble.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    if (state_q == S_ISSUE && xfer) begin
      if (step_q == LAST_STEP) begin
        step_d  = '0;
        phase_d = phase_q + PH_W'(1);
      end else begin
        step_d = step_q + LOG_N'(1);
      end
    end
    if (state_d != S_ISSUE) begin
      phase_d = '0;
      step_d  = '0;
    end

    issue_d     = (state_d == S_ISSUE);
    busy_d      = issue_d;
    cmd_valid_d = issue_d;
    done_d      = (state_d == S_FIN);
    cmd_row_d   = issue_d & ~phase_d[0];
    cmd_odd_d   = issue_d & step_d[0];
    cmd_last_d  = issue_d & (phase_d == LAST_PHASE) & (step_d == LAST_STEP);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_odd   = cmd_odd_q;
  assign cmd_phase = phase_q;
  assign cmd_step  = step_q;
  assign cmd_last  = cmd_last_q;

endmodule

// File: tb/tb_mesh_sort_sched.sv
// Bench for mesh_sort_sched: randomized cmd_ready/start stimulus checked against
// the shearsort command list built from nested phase/step loops.
module tb_mesh_sort_sched;

  localparam int L     = 2;
  localparam int N     = 4;
  localparam int PW    = 3;
  localparam int TOTAL = N * (2 * L + 1);
  localparam int BUDGET = 400;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_row;
  logic          cmd_odd;
  logic [PW-1:0] cmd_phase;
  logic [L-1:0]  cmd_step;
  logic          cmd_last;

  int n_tests;
  int n_fail;
  int done_total;
  int exp_q[$];

  mesh_sort_sched #(.LOG_N(L), .N(N), .PH_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_row(cmd_row),
    .cmd_odd(cmd_odd),
    .cmd_phase(cmd_phase),
    .cmd_step(cmd_step),
    .cmd_last(cmd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is stable at the falling edge; count pulses slightly after it
  always @(negedge clk) begin
    #1;
    if (done === 1'b1) done_total++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pack_cmd(input int row, input int odd, input int ph,
                                  input int st, input int last);
    return (row << (PW + L + 2)) | (odd << (PW + L + 1)) | (ph << (L + 1)) |
           (st << 1) | last;
  endfunction

  function automatic int obs_cmd();
    return pack_cmd(int'(cmd_row), int'(cmd_odd), int'(cmd_phase),
                    int'(cmd_step), int'(cmd_last));
  endfunction

  function automatic int obs_ctl();
    return int'({busy, done, cmd_valid});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, obs_ctl(), 0);
    check({tag, "_cmd"}, obs_cmd(), 0);
  endtask

  // One sort from IDLE. rmode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random.
  // extra: also pulse start at transfers 5 and 20 and in the FIN cycle.
  // abort_at: if nonzero, reset asynchronously right after that transfer.
  task automatic run_sort(input int rmode, input bit extra, input int abort_at);
    int idx;
    int cyc;
    int d0;
    bit rdy;
    d0    = done_total;
    start = 1'b1;
    cmd_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    cyc   = 0;
    while (idx < TOTAL && cyc < BUDGET) begin
      check("issue_ctl", obs_ctl(), 5);
      check($sformatf("cmd%0d", idx), obs_cmd(), exp_q[idx]);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      cmd_ready = rdy;
      start = extra && rdy && (idx == 4 || idx == TOTAL - 1);
      if (rdy) idx++;
      if (abort_at != 0 && rdy && idx == abort_at) begin
        @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check_idle("rst_async");
        check("rst_no_done", done_total - d0, 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_no_done2", done_total - d0, 0);
        rst = 1'b1;
        cmd_ready = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("no_timeout", int'(cyc < BUDGET), 1);
    cmd_ready = 1'($urandom_range(0, 1));
    check("fin_ctl", obs_ctl(), 2);
    check("fin_cmd", obs_cmd(), 0);
    start = extra;
    @(negedge clk);
    start = 1'b0;
    check_idle("post_fin");
    check("done_once", done_total - d0, 1);
    if (extra) begin
      repeat (5) begin
        cmd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle("sit_idle");
      end
    end
  endtask

  initial begin
    int d;
    n_tests    = 0;
    n_fail     = 0;
    done_total = 0;
    for (int p = 0; p <= 2 * L; p++)
      for (int s = 0; s < N; s++)
        exp_q.push_back(pack_cmd((p + 1) % 2, s % 2, p, s,
                                 int'(p == 2 * L && s == N - 1)));

    rst       = 1'b0;
    start     = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    repeat (10) begin
      cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle("idle");
    end

    run_sort(0, 1'b0, 0);
    run_sort(1, 1'b0, 0);
    run_sort(2, 1'b1, 0);
    run_sort(2, 1'b0, 7);
    run_sort(0, 1'b0, 0);

    d = done_total;
    run_sort(2, 1'b0, 0);
    run_sort(0, 1'b0, 0);
    @(negedge clk);
    check("b2b_done", done_total - d, 2);

    repeat (4) run_sort(2, 1'($urandom_range(0, 1)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
